// File: rtl/led_frame_loader.sv
// led_frame_loader: host row writes into a back buffer, commit snapshots it into a one-deep
// stage, and each staged frame is offered to the matrix controller over enable/ready.
// Define LED_FRAME_REFRESH_EN to re-offer the last frame whenever nothing new is staged.
module led_frame_loader #(
    parameter int NUM_ROWS = 8,
    parameter int ROW_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wrEn,
    input  logic [$clog2(NUM_ROWS)-1:0] wrRow,
    input  logic [ROW_W-1:0]            wrData,
    input  logic                        commit,
    output logic [NUM_ROWS*ROW_W-1:0]   matrixOut,
    output logic                        enable,
    input  logic                        ready,
    output logic                        busy,
    output logic                        frameSent,
    output logic                        dropped
);
    localparam int FRAME_W   = NUM_ROWS * ROW_W;
    localparam int ROW_IDX_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, OFFER, DRAIN, SCAN} stateT;

    stateT              state, stateNext;
    logic [FRAME_W-1:0] backBuf, backNext;
    logic [FRAME_W-1:0] stageBuf;
    logic               stageValid, stageValidNext;
    logic               consume, accept, dropNext;
`ifdef LED_FRAME_REFRESH_EN
    logic               hasSent;
`endif

    // Back buffer with this cycle's row write folded in, so a same-cycle commit captures it.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        backNext = backBuf;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (wrEn && wrRow == ROW_IDX_W'(r)) begin
                backNext[FRAME_W-1-ROW_W*r -: ROW_W] = wrData;
            end
        end
    end

    always_comb begin
        stateNext = state;
        consume   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (stageValid) begin
                    consume   = 1'b1;
                    stateNext = OFFER;
                end
`ifdef LED_FRAME_REFRESH_EN
                else if (hasSent) begin
                    stateNext = OFFER;
                end
`endif
            end
            OFFER: begin
                if (enable && ready) begin
                    accept    = 1'b1;
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (!ready) begin
                    stateNext = SCAN;
                end
            end
            SCAN: begin
                if (ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // A commit always refills the stage; it only counts as a drop if the old frame was never taken.
        stageValidNext = commit | (stageValid & ~consume);
        dropNext       = commit & stageValid & ~consume;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the frame buffers are plain flops rather than a RAM, so they reset like any other state.
            state      <= IDLE;
            backBuf    <= '0;
            stageBuf   <= '0;
            stageValid <= 1'b0;
            matrixOut  <= '0;
            enable     <= 1'b0;
            busy       <= 1'b0;
            frameSent  <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= stateNext;
            backBuf    <= backNext;
            stageValid <= stageValidNext;
            if (commit) begin
                stageBuf <= backNext;
            end
            if (consume) begin
                matrixOut <= stageBuf;
            end
            enable    <= (stateNext == OFFER);
            busy      <= (stateNext != IDLE) | stageValidNext;
            frameSent <= accept;
            dropped   <= dropNext;
        end
    end

`ifdef LED_FRAME_REFRESH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hasSent <= 1'b0;
        end else if (accept) begin
            hasSent <= 1'b1;
        end
    end
`endif

endmodule
